// File: rtl/mem_io_responder.sv
// Memory-stage request responder: serves core load/store/print/scan strobes over a
// valid/ready data-memory port or UART byte streams, stalling the core meanwhile.
module mem_io_responder #(
    parameter int unsigned MEM_AW     = 25,
    parameter int unsigned SCAN_BYTES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_en,
    input  logic              LwM,
    input  logic              MemWriteM,
    input  logic              printM,
    input  logic              scanM,
    input  logic [31:0]       MemAddrM,
    input  logic [31:0]       WriteDataM,
    output logic              stall_m,
    output logic              valid_mem,
    output logic [31:0]       ReadDataMEMW,
    output logic              valid_in,
    output logic [31:0]       ReadDataIOW,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [7:0]        rx_data
);

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MEM_REQ  = 3'd1,
        MEM_WAIT = 3'd2,
        TX       = 3'd3,
        RX       = 3'd4,
        DONE     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        K_LOAD  = 2'd0,
        K_STORE = 2'd1,
        K_PRINT = 2'd2,
        K_SCAN  = 2'd3
    } kind_e;

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   scan_buf_q, scan_buf_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [WORD_W-1:0]   rd_mem_q, rd_mem_d;
    logic [WORD_W-1:0]   rd_io_q, rd_io_d;
    logic                valid_mem_q, valid_mem_d;
    logic                valid_in_q, valid_in_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                mem_we_q, mem_we_d;
    logic                tx_valid_q, tx_valid_d;
    logic                rx_ready_q, rx_ready_d;

    logic                req;
    logic [WORD_W-1:0]   scan_word;
    logic                unused_addr_bits;

    assign req = core_en & (LwM | MemWriteM | printM | scanM);
    assign unused_addr_bits = ^{MemAddrM[31:MEM_AW+2], MemAddrM[1:0]};

    // Held low during reset so the core never sees a stall from a discarded request
    assign stall_m = reset & (((state_q == IDLE) & req) |
                              (state_q == MEM_REQ) | (state_q == MEM_WAIT) |
                              (state_q == TX) | (state_q == RX));

    // Next-state, datapath captures and registered handshake decodes
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        scan_buf_d  = scan_buf_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_data_d   = tx_data_q;
        rd_mem_d    = rd_mem_q;
        rd_io_d     = rd_io_q;
        scan_word   = scan_buf_q;
        scan_word[{cnt_q, 3'b000} +: 8] = rx_data;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (scanM)       kind_d = K_SCAN;
                    else if (printM) kind_d = K_PRINT;
                    else if (LwM)    kind_d = K_LOAD;
                    else             kind_d = K_STORE;
                    mem_addr_d  = MemAddrM[MEM_AW+1:2];
                    mem_wdata_d = WriteDataM;
                    tx_data_d   = WriteDataM[7:0];
                    cnt_d       = '0;
                    scan_buf_d  = '0;
                    if (scanM)       state_d = RX;
                    else if (printM) state_d = TX;
                    else             state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (mem_req_ready) begin
                    state_d = (kind_q == K_STORE) ? DONE : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    rd_mem_d = mem_resp_data;
                    state_d  = DONE;
                end
            end
            TX: begin
                if (tx_ready) state_d = DONE;
            end
            RX: begin
                if (rx_valid) begin
                    scan_buf_d = scan_word;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SCAN_BYTES - 1)) begin
                        rd_io_d = scan_word;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_req_valid_d = (state_d == MEM_REQ);
        mem_we_d        = (state_d == MEM_REQ) && (kind_d == K_STORE);
        tx_valid_d      = (state_d == TX);
        rx_ready_d      = (state_d == RX);
        valid_mem_d     = (state_d == DONE) && (kind_d == K_LOAD);
        valid_in_d      = (state_d == DONE) && (kind_d == K_SCAN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            kind_q          <= K_LOAD;
            cnt_q           <= '0;
            scan_buf_q      <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            tx_data_q       <= '0;
            rd_mem_q        <= '0;
            rd_io_q         <= '0;
            valid_mem_q     <= 1'b0;
            valid_in_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            tx_valid_q      <= 1'b0;
            rx_ready_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            kind_q          <= kind_d;
            cnt_q           <= cnt_d;
            scan_buf_q      <= scan_buf_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            tx_data_q       <= tx_data_d;
            rd_mem_q        <= rd_mem_d;
            rd_io_q         <= rd_io_d;
            valid_mem_q     <= valid_mem_d;
            valid_in_q      <= valid_in_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            tx_valid_q      <= tx_valid_d;
            rx_ready_q      <= rx_ready_d;
        end
    end

    assign valid_mem     = valid_mem_q;
    assign ReadDataMEMW  = rd_mem_q;
    assign valid_in      = valid_in_q;
    assign ReadDataIOW   = rd_io_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign rx_ready      = rx_ready_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a 4-byte-scan instance exercises every path,
// a 1-byte-scan instance (enabled separately) covers the zero-extended scan.
module tb_mem_io_responder;

    localparam int unsigned MEM_AW = 25;

    logic              clk;
    logic              reset;
    logic              core_en, core_en1;
    logic              LwM, MemWriteM, printM, scanM;
    logic [31:0]       MemAddrM, WriteDataM;
    logic              mem_req_ready, mem_resp_valid;
    logic [31:0]       mem_resp_data;
    logic              tx_ready, rx_valid;
    logic [7:0]        rx_data;

    logic              stall_m, valid_mem, valid_in, mem_req_valid, mem_we, tx_valid, rx_ready;
    logic [31:0]       ReadDataMEMW, ReadDataIOW, mem_wdata;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        tx_data;

    logic              stall_m1, valid_mem1, valid_in1, mem_req_valid1, mem_we1, tx_valid1, rx_ready1;
    logic [31:0]       ReadDataMEMW1, ReadDataIOW1, mem_wdata1;
    logic [MEM_AW-1:0] mem_addr1;
    logic [7:0]        tx_data1;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned stall_cnt = 0;
    logic [31:0] q_mem[$];
    logic [31:0] q_in4[$];
    logic [31:0] q_in1[$];
    logic [7:0]  bytes4 [4];

    mem_io_responder #(.MEM_AW(MEM_AW), .SCAN_BYTES(4)) u4 (
        .clk(clk), .reset(reset), .core_en(core_en),
        .LwM(LwM), .MemWriteM(MemWriteM), .printM(printM), .scanM(scanM),
        .MemAddrM(MemAddrM), .WriteDataM(WriteDataM),
        .stall_m(stall_m), .valid_mem(valid_mem), .ReadDataMEMW(ReadDataMEMW),
        .valid_in(valid_in), .ReadDataIOW(ReadDataIOW),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data)
    );

    mem_io_responder #(.MEM_AW(MEM_AW), .SCAN_BYTES(1)) u1 (
        .clk(clk), .reset(reset), .core_en(core_en1),
        .LwM(LwM), .MemWriteM(MemWriteM), .printM(printM), .scanM(scanM),
        .MemAddrM(MemAddrM), .WriteDataM(WriteDataM),
        .stall_m(stall_m1), .valid_mem(valid_mem1), .ReadDataMEMW(ReadDataMEMW1),
        .valid_in(valid_in1), .ReadDataIOW(ReadDataIOW1),
        .mem_req_valid(mem_req_valid1), .mem_req_ready(mem_req_ready), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .tx_valid(tx_valid1), .tx_ready(tx_ready), .tx_data(tx_data1),
        .rx_valid(rx_valid), .rx_ready(rx_ready1), .rx_data(rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake/pulse outputs of the 4-byte instance packed for all-zero checks
    function automatic logic [31:0] hs4();
        return 32'({stall_m, valid_mem, valid_in, mem_req_valid, mem_we, tx_valid, rx_ready});
    endfunction

    // Scoreboard: completions pop the expected data; a pulse with nothing queued is spurious
    always @(negedge clk) begin
        if (stall_m) stall_cnt++;
        if (valid_mem) begin
            if (q_mem.size() == 0) chk("valid_mem_spurious", 32'(valid_mem), 32'd0);
            else                   chk("ReadDataMEMW", ReadDataMEMW, q_mem.pop_front());
        end
        if (valid_in) begin
            if (q_in4.size() == 0) chk("valid_in_spurious", 32'(valid_in), 32'd0);
            else                   chk("ReadDataIOW", ReadDataIOW, q_in4.pop_front());
        end
        if (valid_in1) begin
            if (q_in1.size() == 0) chk("valid_in1_spurious", 32'(valid_in1), 32'd0);
            else                   chk("ReadDataIOW1", ReadDataIOW1, q_in1.pop_front());
        end
        if (valid_mem1) chk("valid_mem1_spurious", 32'(valid_mem1), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; core_en = 1'b1; core_en1 = 1'b0;
        LwM = 1'b0; MemWriteM = 1'b0; printM = 1'b0; scanM = 1'b0;
        MemAddrM = '0; WriteDataM = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        bytes4[0] = 8'h78; bytes4[1] = 8'h56; bytes4[2] = 8'h34; bytes4[3] = 8'h12;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_handshake", hs4(), 32'd0);
        chk("rst_ReadDataMEMW", ReadDataMEMW, 32'd0);
        chk("rst_ReadDataIOW", ReadDataIOW, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        tick(); reset = 1'b1;
        tick();

        // Load, zero-wait request, response two cycles after accept
        tick(); LwM = 1'b1; MemAddrM = 32'h0000_0100; mem_req_ready = 1'b1;
        q_mem.push_back(32'hDEADBEEF); stall_cnt = 0;
        @(negedge clk);
        chk("ld_c0_stall", 32'(stall_m), 32'd1);
        chk("ld_c0_reqv", 32'(mem_req_valid), 32'd0);
        tick(); @(negedge clk);
        chk("ld_c1_reqv", 32'(mem_req_valid), 32'd1);
        chk("ld_c1_addr", 32'(mem_addr), 32'h40);
        chk("ld_c1_we", 32'(mem_we), 32'd0);
        tick(); @(negedge clk);
        chk("ld_c2_reqv", 32'(mem_req_valid), 32'd0);
        tick(); mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
        tick(); mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        chk("ld_done_valid_mem", 32'(valid_mem), 32'd1);
        chk("ld_done_stall", 32'(stall_m), 32'd0);
        tick(); LwM = 1'b0;
        @(negedge clk);
        chk("ld_after_valid_mem", 32'(valid_mem), 32'd0);
        chk("ld_stall_cycles", stall_cnt, 32'd4);
        chk("ld_hold_data", ReadDataMEMW, 32'hDEADBEEF);

        // Store with ready held low for three cycles
        tick(); MemWriteM = 1'b1; MemAddrM = 32'h8; WriteDataM = 32'h12345678;
        mem_req_ready = 1'b0; stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_req_ready = 1'b1;
            @(negedge clk);
            chk("st_reqv", 32'(mem_req_valid), 32'd1);
            chk("st_we", 32'(mem_we), 32'd1);
            chk("st_addr", 32'(mem_addr), 32'h2);
            chk("st_wdata", mem_wdata, 32'h12345678);
        end
        tick(); mem_req_ready = 1'b0;
        @(negedge clk);
        chk("st_done_stall", 32'(stall_m), 32'd0);
        chk("st_done_reqv", 32'(mem_req_valid), 32'd0);
        chk("st_done_valid_mem", 32'(valid_mem), 32'd0);
        tick(); MemWriteM = 1'b0;
        @(negedge clk);
        chk("st_stall_cycles", stall_cnt, 32'd5);

        // Print with tx_ready low five cycles
        tick(); printM = 1'b1; WriteDataM = 32'h141; tx_ready = 1'b0; stall_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 5) tx_ready = 1'b1;
            @(negedge clk);
            chk("pr_txv", 32'(tx_valid), 32'd1);
            chk("pr_txd", 32'(tx_data), 32'h41);
        end
        tick(); tx_ready = 1'b0;
        @(negedge clk);
        chk("pr_done_stall", 32'(stall_m), 32'd0);
        chk("pr_done_txv", 32'(tx_valid), 32'd0);
        tick(); printM = 1'b0;
        @(negedge clk);
        chk("pr_stall_cycles", stall_cnt, 32'd7);

        // Four-byte scan with a gap before each beat
        tick(); scanM = 1'b1; q_in4.push_back(32'h12345678); stall_cnt = 0;
        tick(); @(negedge clk);
        chk("sc4_rx_ready", 32'(rx_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(); rx_valid = 1'b1; rx_data = bytes4[i];
            tick(); rx_valid = 1'b0; rx_data = '0;
            if (i < 3) begin
                @(negedge clk);
                chk("sc4_gap_stall", 32'(stall_m), 32'd1);
                chk("sc4_gap_valid_in", 32'(valid_in), 32'd0);
            end
        end
        @(negedge clk);
        chk("sc4_done_valid_in", 32'(valid_in), 32'd1);
        chk("sc4_done_stall", 32'(stall_m), 32'd0);
        tick(); scanM = 1'b0;
        @(negedge clk);
        chk("sc4_hold", ReadDataIOW, 32'h12345678);

        // One-byte scan on the second instance; first instance disabled
        tick(); core_en = 1'b0; core_en1 = 1'b1; scanM = 1'b1; q_in1.push_back(32'h000000FF);
        @(negedge clk);
        chk("sc1_stall", 32'(stall_m1), 32'd1);
        chk("sc1_other_stall", 32'(stall_m), 32'd0);
        tick(); rx_valid = 1'b1; rx_data = 8'hFF;
        @(negedge clk);
        chk("sc1_rx_ready", 32'(rx_ready1), 32'd1);
        tick(); rx_valid = 1'b0; rx_data = '0;
        @(negedge clk);
        chk("sc1_valid_in", 32'(valid_in1), 32'd1);
        chk("sc1_other_hold", ReadDataIOW, 32'h12345678);
        tick(); scanM = 1'b0; core_en1 = 1'b0; core_en = 1'b1;

        // Load and scan together: scan wins, no memory request
        tick(); LwM = 1'b1; scanM = 1'b1; MemAddrM = 32'h40; q_in4.push_back(32'h04030201);
        tick(); rx_valid = 1'b1; rx_data = 8'h01;
        @(negedge clk);
        chk("pri_reqv", 32'(mem_req_valid), 32'd0);
        chk("pri_rx_ready", 32'(rx_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick(); rx_data = 8'(i + 1);
        end
        tick(); rx_valid = 1'b0; rx_data = '0;
        @(negedge clk);
        chk("pri_valid_in", 32'(valid_in), 32'd1);
        chk("pri_valid_mem", 32'(valid_mem), 32'd0);
        tick(); LwM = 1'b0; scanM = 1'b0;

        // Core disabled: strobe is not accepted
        tick(); core_en = 1'b0; LwM = 1'b1;
        repeat (3) begin
            tick(); @(negedge clk);
            chk("dis_stall", 32'(stall_m), 32'd0);
            chk("dis_reqv", 32'(mem_req_valid), 32'd0);
        end
        tick(); LwM = 1'b0; core_en = 1'b1;

        // Reset while waiting for a load response, then a late response
        tick(); LwM = 1'b1; MemAddrM = 32'h200; mem_req_ready = 1'b1;
        tick(); @(negedge clk);
        chk("rmw_reqv", 32'(mem_req_valid), 32'd1);
        chk("rmw_addr", 32'(mem_addr), 32'h80);
        tick(); @(negedge clk);
        chk("rmw_wait_stall", 32'(stall_m), 32'd1);
        tick(); reset = 1'b0; LwM = 1'b0;
        #1;
        chk("rmw_rst_handshake", hs4(), 32'd0);
        chk("rmw_rst_addr", 32'(mem_addr), 32'd0);
        chk("rmw_rst_rdmem", ReadDataMEMW, 32'd0);
        chk("rmw_rst_rdio", ReadDataIOW, 32'd0);
        tick(); tick(); reset = 1'b1;
        tick(); mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D;
        tick(); mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        chk("rmw_late_valid_mem", 32'(valid_mem), 32'd0);
        chk("rmw_late_rdmem", ReadDataMEMW, 32'd0);
        chk("rmw_late_stall", 32'(stall_m), 32'd0);
        tick(); @(negedge clk);
        chk("rmw_late_valid_mem2", 32'(valid_mem), 32'd0);

        chk("q_mem_drained", 32'(q_mem.size()), 32'd0);
        chk("q_in4_drained", 32'(q_in4.size()), 32'd0);
        chk("q_in1_drained", 32'(q_in1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
